// File: rtl/leg_bus_pkg.sv
// -----------------------------------------------------------------------------
// leg_bus_pkg
//
// Purpose : Shared types for the memory bus between memmap, the BRAM arbiter
//           and secondary masters (boot loader, UART DMA).
//
// Contents:
//   BUS_ADDR_W / BUS_DATA_W : widest address/data carried in the structs below
//   DEFAULT_MAX_WAIT        : default starvation limit for arbiters
//   mem_req_t               : one requester's access (req, addr, write, wdata)
//   mem_rsp_t               : one requester's read return (rvalid, rdata)
// -----------------------------------------------------------------------------
package leg_bus_pkg;

    localparam int unsigned BUS_ADDR_W       = 32;
    localparam int unsigned BUS_DATA_W       = 32;
    localparam int unsigned DEFAULT_MAX_WAIT = 4;

    typedef struct packed {
        logic                  req;
        logic [BUS_ADDR_W-1:0] addr;
        logic                  write;
        logic [BUS_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic [BUS_DATA_W-1:0] rdata;
    } mem_rsp_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
//
// Purpose : 8-bit saturating "cycles denied" counter used by arbiters to force
//           a grant to a low-priority requester after MAX_COUNT lost cycles.
//           Clear has priority over increment.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous, active-high reset (count -> 0)
//   i_inc  in   requester was denied this cycle
//   i_clr  in   requester was granted or is idle this cycle
//   o_sat  out  count has reached MAX_COUNT
//
// Parameters:
//   MAX_COUNT : saturation value, legal range 1..255
// -----------------------------------------------------------------------------
module arb_starve_cnt
    import leg_bus_pkg::*;
#(
    parameter int unsigned MAX_COUNT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam logic [7:0] MaxCnt = 8'(MAX_COUNT);

    if (MAX_COUNT < 1 || MAX_COUNT > 255) begin : g_bad_max
        $error("arb_starve_cnt: MAX_COUNT must be in 1..255");
    end

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clr) begin
            w_cnt_next = 8'd0;
        end else if (i_inc && (r_cnt < MaxCnt)) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_sat = (r_cnt >= MaxCnt);

endmodule

// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
//
// Purpose : Shares one single-port BRAM between port 0 (CPU path from memmap)
//           and port 1 (boot loader / UART DMA). Port 0 has fixed priority;
//           after MAX_WAIT consecutive denied cycles port 1 is force-granted.
//           The granted access goes to the BRAM in the same cycle and read
//           data comes back one cycle later with a per-port valid strobe.
//
// Parameters:
//   DATA_WIDTH : data word width (<= leg_bus_pkg::BUS_DATA_W)
//   ADDR_WIDTH : address width   (<= leg_bus_pkg::BUS_ADDR_W)
//   MAX_WAIT   : denied cycles before port 1 is forced, 1..255
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mX_req/addr/write/wdata      requester X access (X = 0, 1)
//   mX_gnt                       access taken this cycle (combinational)
//   mX_rvalid/rdata              read return, one cycle after a granted read
//   m1_lock                      (BRAM_ARBITER_LOCK_EN only) keep port 1 owning
//                                the BRAM across consecutive beats
//   bram_addr/write/data_in      to the BRAM; all zero when nothing is granted
//   bram_data_out                from the BRAM, 1-cycle read latency
//
// Build option:
//   BRAM_ARBITER_LOCK_EN : adds m1_lock and the lock state bit.
// -----------------------------------------------------------------------------
module bram_arbiter
    import leg_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = DEFAULT_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
`ifdef BRAM_ARBITER_LOCK_EN
    input  logic                  m1_lock,
`endif
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_write,
    output logic [DATA_WIDTH-1:0] bram_data_in,
    input  logic [DATA_WIDTH-1:0] bram_data_out
);

    if (ADDR_WIDTH > BUS_ADDR_W || DATA_WIDTH > BUS_DATA_W) begin : g_bad_width
        $error("bram_arbiter: ADDR_WIDTH/DATA_WIDTH exceed leg_bus_pkg bus widths");
    end

    mem_req_t w_m0;
    mem_req_t w_m1;
    mem_req_t w_sel;
    mem_rsp_t w_rsp0;
    mem_rsp_t w_rsp1;

    logic w_gnt0;
    logic w_gnt1;
    logic w_sat;
    logic w_locked;
    logic w_cnt_inc;
    logic w_cnt_clr;

    logic rpend_q;
    logic rsel_q;

    // -------------------------------------------------------------------------
    // Requests into bus structs
    // -------------------------------------------------------------------------
    always_comb begin
        w_m0       = '0;
        w_m0.req   = m0_req;
        w_m0.addr  = BUS_ADDR_W'(m0_addr);
        w_m0.write = m0_write;
        w_m0.wdata = BUS_DATA_W'(m0_wdata);

        w_m1       = '0;
        w_m1.req   = m1_req;
        w_m1.addr  = BUS_ADDR_W'(m1_addr);
        w_m1.write = m1_write;
        w_m1.wdata = BUS_DATA_W'(m1_wdata);
    end

    // -------------------------------------------------------------------------
    // Optional port 1 lock
    // -------------------------------------------------------------------------
`ifdef BRAM_ARBITER_LOCK_EN
    logic lock_q;
    logic w_lock_next;

    always_comb begin
        w_lock_next = lock_q;
        if (!m1_req) begin
            w_lock_next = 1'b0;
        end else if (w_gnt1) begin
            w_lock_next = m1_lock;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= w_lock_next;
        end
    end

    assign w_locked = lock_q;
`else
    assign w_locked = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Grant: port 0 priority, starvation override, lock override.
    // Not gated by rst on purpose: grants track req even during reset.
    // -------------------------------------------------------------------------
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_locked) begin
            w_gnt1 = m1_req;
        end else if (m1_req && (w_sat || !m0_req)) begin
            w_gnt1 = 1'b1;
        end else begin
            w_gnt0 = m0_req;
        end
    end

    assign m0_gnt = w_gnt0;
    assign m1_gnt = w_gnt1;

    // Counter is parked at zero while port 1 holds the lock.
    assign w_cnt_inc = m1_req && !w_gnt1 && !w_locked;
    assign w_cnt_clr = w_gnt1 || !m1_req || w_locked;

    arb_starve_cnt #(
        .MAX_COUNT (MAX_WAIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_cnt_inc),
        .i_clr (w_cnt_clr),
        .o_sat (w_sat)
    );

    // -------------------------------------------------------------------------
    // BRAM mux; an all-zero struct when idle keeps the BRAM bus quiet.
    // -------------------------------------------------------------------------
    always_comb begin
        w_sel = '0;
        if (w_gnt0) begin
            w_sel = w_m0;
        end else if (w_gnt1) begin
            w_sel = w_m1;
        end
    end

    assign bram_addr    = ADDR_WIDTH'(w_sel.addr);
    assign bram_write   = w_sel.write;
    assign bram_data_in = DATA_WIDTH'(w_sel.wdata);

    // -------------------------------------------------------------------------
    // Read return tracking: one outstanding read per cycle, so a single
    // pending bit plus owner is enough to pipeline alternating reads.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rpend_q <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            rpend_q <= w_sel.req && !w_sel.write;
            rsel_q  <= w_gnt1;
        end
    end

    always_comb begin
        w_rsp0        = '0;
        w_rsp1        = '0;
        w_rsp0.rvalid = rpend_q && !rsel_q;
        w_rsp1.rvalid = rpend_q && rsel_q;
        if (w_rsp0.rvalid) begin
            w_rsp0.rdata = BUS_DATA_W'(bram_data_out);
        end
        if (w_rsp1.rvalid) begin
            w_rsp1.rdata = BUS_DATA_W'(bram_data_out);
        end
    end

    assign m0_rvalid = w_rsp0.rvalid;
    assign m0_rdata  = DATA_WIDTH'(w_rsp0.rdata);
    assign m1_rvalid = w_rsp1.rvalid;
    assign m1_rdata  = DATA_WIDTH'(w_rsp1.rdata);

endmodule

// File: tb/tb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_arbiter
//
// Table-driven bench: each row is one clock cycle of inputs plus the expected
// grants. BRAM bus outputs follow from the row and its expected grant; read
// returns are pushed to a scoreboard when a read is granted and popped one
// cycle later. A small BRAM model with 1-cycle read latency backs the DUT.
// Build with +define+BRAM_ARBITER_LOCK_EN to add the lock rows.
// -----------------------------------------------------------------------------
module tb_bram_arbiter;

    localparam int unsigned DW       = 32;
    localparam int unsigned AW       = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_write, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_write, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
`ifdef BRAM_ARBITER_LOCK_EN
    logic          m1_lock;
`endif
    logic [AW-1:0] bram_addr;
    logic          bram_write;
    logic [DW-1:0] bram_data_in;
    logic [DW-1:0] bram_data_out;

    always #5 clk = ~clk;

    bram_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req        (m0_req),
        .m0_addr       (m0_addr),
        .m0_write      (m0_write),
        .m0_wdata      (m0_wdata),
        .m0_gnt        (m0_gnt),
        .m0_rvalid     (m0_rvalid),
        .m0_rdata      (m0_rdata),
        .m1_req        (m1_req),
        .m1_addr       (m1_addr),
        .m1_write      (m1_write),
        .m1_wdata      (m1_wdata),
`ifdef BRAM_ARBITER_LOCK_EN
        .m1_lock       (m1_lock),
`endif
        .m1_gnt        (m1_gnt),
        .m1_rvalid     (m1_rvalid),
        .m1_rdata      (m1_rdata),
        .bram_addr     (bram_addr),
        .bram_write    (bram_write),
        .bram_data_in  (bram_data_in),
        .bram_data_out (bram_data_out)
    );

    // BRAM model: word-addressed, read-before-write, 1-cycle latency.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (bram_write) mem[bram_addr[11:2]] <= bram_data_in;
        bram_data_out <= mem[bram_addr[11:2]];
    end

    typedef struct {
        logic          rst;
        logic          r0;
        logic [AW-1:0] a0;
        logic          w0;
        logic [DW-1:0] d0;
        logic          r1;
        logic [AW-1:0] a1;
        logic          w1;
        logic [DW-1:0] d1;
        logic          lk;
        logic          g0;
        logic          g1;
    } vec_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } rd_exp_t;

    vec_t          tbl[$];
    rd_exp_t       sb[$];
    logic [DW-1:0] shadow [0:1023];
    int            checks = 0;
    int            errors = 0;

    function automatic vec_t mk(input logic rs, input logic r0, input logic [AW-1:0] a0,
                                input logic w0, input logic [DW-1:0] d0, input logic r1,
                                input logic [AW-1:0] a1, input logic w1,
                                input logic [DW-1:0] d1, input logic lk, input logic g0,
                                input logic g1);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.a0 = a0; v.w0 = w0; v.d0 = d0;
        v.r1 = r1;  v.a1 = a1; v.w1 = w1; v.d1 = d1; v.lk = lk;
        v.g0 = g0;  v.g1 = g1;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rd_exp_t       e;
        logic [AW-1:0] ea;
        logic          ew;
        logic [DW-1:0] ed;
        logic          any;
        @(posedge clk);
        #1;
        rst      = v.rst;
        m0_req   = v.r0; m0_addr = v.a0; m0_write = v.w0; m0_wdata = v.d0;
        m1_req   = v.r1; m1_addr = v.a1; m1_write = v.w1; m1_wdata = v.d1;
`ifdef BRAM_ARBITER_LOCK_EN
        m1_lock  = v.lk;
`endif
        #3;
        // Read return from the previous cycle
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("row%0d m0_rvalid", idx), m0_rvalid, !e.port);
            chk($sformatf("row%0d m1_rvalid", idx), m1_rvalid, e.port);
            chk($sformatf("row%0d m0_rdata", idx), m0_rdata, e.port ? 32'd0 : e.data);
            chk($sformatf("row%0d m1_rdata", idx), m1_rdata, e.port ? e.data : 32'd0);
        end else begin
            chk($sformatf("row%0d m0_rvalid", idx), m0_rvalid, 0);
            chk($sformatf("row%0d m1_rvalid", idx), m1_rvalid, 0);
            chk($sformatf("row%0d m0_rdata", idx), m0_rdata, 0);
            chk($sformatf("row%0d m1_rdata", idx), m1_rdata, 0);
        end
        chk($sformatf("row%0d m0_gnt", idx), m0_gnt, v.g0);
        chk($sformatf("row%0d m1_gnt", idx), m1_gnt, v.g1);
        any = v.g0 | v.g1;
        ea  = v.g0 ? v.a0 : (v.g1 ? v.a1 : '0);
        ew  = v.g0 ? v.w0 : (v.g1 ? v.w1 : 1'b0);
        ed  = v.g0 ? v.d0 : (v.g1 ? v.d1 : '0);
        chk($sformatf("row%0d bram_addr", idx), bram_addr, ea);
        chk($sformatf("row%0d bram_write", idx), bram_write, ew);
        chk($sformatf("row%0d bram_data_in", idx), bram_data_in, ed);
        if (any && ew) shadow[ea[11:2]] = ed;
        if (any && !ew && !v.rst) sb.push_back('{port: v.g1, data: shadow[ea[11:2]]});
    endtask

    initial begin
        int  waited;
        bit  got;

        rst = 1'b1;
        m0_req = 0; m0_addr = 0; m0_write = 0; m0_wdata = 0;
        m1_req = 0; m1_addr = 0; m1_write = 0; m1_wdata = 0;
`ifdef BRAM_ARBITER_LOCK_EN
        m1_lock = 0;
`endif

        // Reset, idle bus
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // m0 write 44 @'h100, read it back; preload other words on the way
        tbl.push_back(mk(0, 1, 'h100, 1, 44, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h10, 1, 'h1010, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h20, 1, 'h2020, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h4, 1, 7, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h8, 1, 9, 0, 0, 1));
        tbl.push_back(idle());
        // Both reading continuously: m1 forced every 5th cycle
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h20, 0, 0, 0, (i % 5) != 4, (i % 5) == 4));
        tbl.push_back(idle());
        // Alternating single reads pipeline without bubbles
        tbl.push_back(mk(0, 1, 'h4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h8, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h8, 0, 0, 0, 0, 1));
        tbl.push_back(idle());
        // m1 drops mid-wait: count restarts from zero
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h20, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h20, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h20, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h20, 0, 0, 0, 0, 1));
        tbl.push_back(idle());
        // Reset right after a granted read; read in the reset cycle is dropped
        tbl.push_back(mk(0, 1, 'h100, 0, 0, 1, 'h20, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 'h100, 0, 0, 1, 'h20, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h20, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h20, 0, 0, 0, 0, 1));
        tbl.push_back(idle());
        tbl.push_back(idle());
`ifdef BRAM_ARBITER_LOCK_EN
        // Locked 3-beat m1 write burst starting at the forced grant
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h30, 1, 'h3030, 1, 1, 0));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h30, 1, 'h3030, 1, 0, 1));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h34, 1, 'h3131, 1, 0, 1));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 1, 'h38, 1, 'h3232, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(idle());
`endif

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Hand sequence: writes on both ports, bounded wait for the forced m1 grant
        waited = 0;
        got    = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(posedge clk);
            #1;
            rst = 0;
            m0_req = 1; m0_addr = 'h40; m0_write = 1; m0_wdata = 'h4040;
            m1_req = 1; m1_addr = 'h44; m1_write = 1; m1_wdata = 'h4444;
            #3;
            chk("starve one-hot", {31'd0, m0_gnt & m1_gnt}, 0);
            if (m1_gnt) got = 1;
            else waited++;
        end
        chk("starve grant seen", {31'd0, got}, 1);
        chk("starve wait cycles", waited, MAX_WAIT);
        @(posedge clk);
        #1;
        m0_req = 0; m1_req = 0;
        #3;
        chk("final bram_write", bram_write, 0);
        chk("scoreboard drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
